// File: rtl/qar_can_tx_sched.sv
// CAN transmit mailbox scheduler: holds NUM_MB TX mailboxes and offers the lowest-ID
// pending frame to the bit engine, with arbitration requeue, error retry, abort and sticky status.
module qar_can_tx_sched #(
    parameter int unsigned NUM_MB    = 4,
    parameter int unsigned ID_WIDTH  = 11,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   mb_wr_en,
    input  logic [((NUM_MB > 1) ? $clog2(NUM_MB) : 1)-1:0] mb_wr_idx,
    input  logic [ID_WIDTH-1:0]                    mb_wr_id,
    input  logic [3:0]                             mb_wr_dlc,
    input  logic [63:0]                            mb_wr_data,
    input  logic                                   mb_abort_en,
    input  logic [((NUM_MB > 1) ? $clog2(NUM_MB) : 1)-1:0] mb_abort_idx,
    input  logic [NUM_MB-1:0]                      stat_clr,
    output logic [NUM_MB-1:0]                      mb_pending,
    output logic [NUM_MB-1:0]                      mb_done,
    output logic [NUM_MB-1:0]                      mb_fail,
    output logic [NUM_MB-1:0]                      mb_aborted,
    output logic                                   mb_wr_err,
    output logic                                   irq,
    output logic                                   tx_valid,
    input  logic                                   tx_ready,
    output logic [ID_WIDTH-1:0]                    tx_id,
    output logic [3:0]                             tx_dlc,
    output logic [63:0]                            tx_data,
    input  logic                                   tx_done,
    input  logic                                   tx_arb_lost,
    input  logic                                   tx_error
);

    localparam int unsigned IDX_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
    localparam int unsigned RTY_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_OFFER, S_BUSY} state_t;

    state_t state, state_n;

    logic [ID_WIDTH-1:0] mb_id   [NUM_MB];
    logic [3:0]          mb_dlc  [NUM_MB];
    logic [63:0]         mb_data [NUM_MB];
    logic [RTY_W-1:0]    retry_q [NUM_MB];
    logic [RTY_W-1:0]    retry_n [NUM_MB];

    logic [IDX_W-1:0]    win_idx, win_n, sel_idx, lock_idx;
    logic [ID_WIDTH-1:0] sel_id;
    logic                sel_any, lock_active;
    logic                wr_hit_lock, wr_ok, ab_lock, ab_free;
    logic                abort_pend, abort_pend_n, load_tx;
    logic [NUM_MB-1:0]   pend_n, done_n, fail_n, abrt_n;
    logic [RTY_W-1:0]    rty_inc;
    logic [3:0]          wr_dlc_sat;

    // Winner search: strict less-than keeps the lowest index on equal IDs
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        sel_id  = '0;
        for (int i = 0; i < int'(NUM_MB); i++) begin
            if (mb_pending[i] && (!sel_any || (mb_id[i] < sel_id))) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
                sel_id  = mb_id[i];
            end
        end
    end

    // During SELECT the mailbox being snapshotted is the live winner
    always_comb begin
        lock_idx    = (state == S_SELECT) ? sel_idx : win_idx;
        lock_active = (state != S_IDLE) && ((state != S_SELECT) || sel_any);
        wr_hit_lock = mb_wr_en && lock_active && (mb_wr_idx == lock_idx);
        wr_ok       = mb_wr_en && !wr_hit_lock && (32'(mb_wr_idx) < NUM_MB);
        ab_lock     = mb_abort_en && lock_active && (mb_abort_idx == lock_idx);
        ab_free     = mb_abort_en && !ab_lock && (32'(mb_abort_idx) < NUM_MB);
        wr_dlc_sat  = (mb_wr_dlc > 4'd8) ? 4'd8 : mb_wr_dlc;
    end

    always_comb begin
        state_n      = state;
        win_n        = win_idx;
        load_tx      = 1'b0;
        pend_n       = mb_pending;
        done_n       = mb_done & ~stat_clr;
        fail_n       = mb_fail & ~stat_clr;
        abrt_n       = mb_aborted & ~stat_clr;
        retry_n      = retry_q;
        abort_pend_n = abort_pend;
        rty_inc      = retry_q[win_idx] + RTY_W'(1);

        if (ab_free && mb_pending[mb_abort_idx]) begin
            pend_n[mb_abort_idx] = 1'b0;
            abrt_n[mb_abort_idx] = 1'b1;
        end

        if (wr_ok) begin
            pend_n[mb_wr_idx]  = 1'b1;
            done_n[mb_wr_idx]  = 1'b0;
            fail_n[mb_wr_idx]  = 1'b0;
            abrt_n[mb_wr_idx]  = 1'b0;
            retry_n[mb_wr_idx] = '0;
        end

        case (state)
            S_IDLE: begin
                if (|mb_pending) state_n = S_SELECT;
            end
            S_SELECT: begin
                if (!sel_any) begin
                    state_n = S_IDLE;
                end else if (ab_lock) begin
                    pend_n[sel_idx] = 1'b0;
                    abrt_n[sel_idx] = 1'b1;
                    state_n         = S_IDLE;
                end else begin
                    win_n   = sel_idx;
                    load_tx = 1'b1;
                    state_n = S_OFFER;
                end
            end
            S_OFFER: begin
                // Handshake beats a same-cycle abort; the abort is then held for BUSY
                if (tx_valid && tx_ready) begin
                    state_n = S_BUSY;
                    if (ab_lock) abort_pend_n = 1'b1;
                end else if (ab_lock) begin
                    pend_n[win_idx] = 1'b0;
                    abrt_n[win_idx] = 1'b1;
                    state_n         = S_IDLE;
                end
            end
            S_BUSY: begin
                if (ab_lock) abort_pend_n = 1'b1;
                if (tx_done) begin
                    pend_n[win_idx] = 1'b0;
                    done_n[win_idx] = 1'b1;
                    abort_pend_n    = 1'b0;
                    state_n         = S_IDLE;
                end else if (tx_arb_lost || tx_error) begin
                    if (abort_pend || ab_lock) begin
                        pend_n[win_idx] = 1'b0;
                        abrt_n[win_idx] = 1'b1;
                    end else if (tx_error) begin
                        retry_n[win_idx] = rty_inc;
                        if (rty_inc >= RTY_W'(MAX_RETRY)) begin
                            pend_n[win_idx] = 1'b0;
                            fail_n[win_idx] = 1'b1;
                        end
                    end
                    abort_pend_n = 1'b0;
                    state_n      = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_pending <= '0;
            mb_done    <= '0;
            mb_fail    <= '0;
            mb_aborted <= '0;
            mb_wr_err  <= 1'b0;
            irq        <= 1'b0;
            tx_valid   <= 1'b0;
            tx_id      <= '0;
            tx_dlc     <= '0;
            tx_data    <= '0;
            win_idx    <= '0;
            abort_pend <= 1'b0;
            for (int i = 0; i < int'(NUM_MB); i++) begin
                mb_id[i]   <= '0;
                mb_dlc[i]  <= '0;
                mb_data[i] <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            mb_pending <= pend_n;
            mb_done    <= done_n;
            mb_fail    <= fail_n;
            mb_aborted <= abrt_n;
            mb_wr_err  <= wr_hit_lock;
            irq        <= |(done_n | fail_n | abrt_n);
            tx_valid   <= (state_n == S_OFFER);
            win_idx    <= win_n;
            abort_pend <= abort_pend_n;
            retry_q    <= retry_n;
            if (load_tx) begin
                tx_id   <= mb_id[sel_idx];
                tx_dlc  <= mb_dlc[sel_idx];
                tx_data <= mb_data[sel_idx];
            end
            if (wr_ok) begin
                mb_id[mb_wr_idx]   <= mb_wr_id;
                mb_dlc[mb_wr_idx]  <= wr_dlc_sat;
                mb_data[mb_wr_idx] <= mb_wr_data;
            end
        end
    end

endmodule
